peripheral_uart_fifo: RTL and testbench
=======================================

Name: peripheral_uart_fifo

Overview:
- Memory-mapped UART peripheral with parametrised TX/RX FIFOs, a runtime-programmable baud divisor, sticky error flags and a level interrupt.
- Sits on the SoC peripheral bus (cs/rd/wr/addr/d_in/d_out) beside the other perip_* blocks.
- Contains its own 16x-oversampled baud generator, TX shifter and RX sampler, so software never hand-shakes individual bytes.

Parameters:
- clk_freq, 25000000: system clock in Hz. Used only to compute the reset value of BAUD_DIV.
- baud, 115200: reset baud rate. BAUD_DIV resets to clk_freq/(16*baud)-1, truncated.
- fifo_depth, 16: entries per FIFO. Power of 2, range 2..256.
- data_bits, 8: character width, range 5..8. Unused upper data bits read 0 and are ignored on write.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- d_in  in  32  bus write data.
- cs  in  1  peripheral select.
- addr  in  5  byte address; bits [1:0] ignored.
- rd  in  1  read strobe, qualified by cs.
- wr  in  1  write strobe, qualified by cs.
- d_out  out  32  registered read data.
- uart_tx  out  1  serial out; idles high.
- uart_rx  in  1  serial in; asynchronous.
- irq  out  1  level interrupt.
- ledout  out  1  mirrors CTRL[7].

Behaviour:
- Reset (rst=0, async): all FIFOs empty, FSMs IDLE, CTRL=0, sticky flags 0, BAUD_DIV=reset value, d_out=0, uart_tx=1, irq=0, ledout=0. Both RX synchroniser flops reset to 1.
- Register map:
  - 0x00 DATA. Write pushes to TX FIFO. Read returns {0, RX head} and pops.
  - 0x04 STATUS: [0] rx_avail, [1] rx_full, [2] tx_empty, [3] tx_full, [4] tx_busy, [5] rx_ovf, [6] frame_err, [7] tx_ovf, [8] parity_err. Bits [8:5] are sticky and write-1-to-clear.
  - 0x08 CTRL: [0] rx_en, [1] tx_en, [2] ie_rx, [3] ie_tx, [4] ie_err, [5] parity_odd, [6] parity_on, [7] led. Read/write.
  - 0x0C BAUD_DIV: [15:0], read/write.
  - 0x10 LEVEL: [8:0] rx_count, [24:16] tx_count. Read-only.
  - Other addresses: read 0, writes ignored.
- Read latency: d_out is valid one cycle after cs&rd. d_out=0 in any cycle without cs&rd.
- DATA pop happens in the same edge that captures the head.
- Read of DATA with RX FIFO empty returns 0 and does not pop.
- Write of DATA with TX FIFO full drops the byte and sets tx_ovf.
- Baud tick: a 16-bit counter counts down from BAUD_DIV and emits a 1-cycle tick on reaching 0, then reloads. A write to BAUD_DIV reloads the counter immediately.
- TX FSM, transitions on every 16th tick:
  - IDLE -> START when tx_en and the TX FIFO is non-empty; pop occurs on entering START.
  - START -> DATA (LSB first, data_bits bits) -> [PARITY] -> STOP -> IDLE.
  - Clearing tx_en mid-frame completes the current frame.
  - tx_busy=1 whenever not in IDLE.
- RX FSM, sampled on ticks via a 2-flop synchroniser:
  - IDLE: a falling edge while rx_en -> START.
  - START: at sample 8, line still low -> DATA; line high -> IDLE (glitch reject).
  - DATA: sample each bit at sample 8 of its bit time -> [PARITY] -> STOP.
  - STOP: sampled low sets frame_err and discards the byte. A parity mismatch sets parity_err and discards the byte.
  - Valid byte with RX FIFO full: byte dropped, rx_ovf set.
- Simultaneous push and pop on one FIFO in the same cycle: both occur and the count is unchanged. This is legal even when full (pop frees the slot first) or when empty only for push.
- Pointers are log2(fifo_depth)+1 bits wide. Full and empty are decoded from the MSB difference, so wrap-around needs no special case.
- irq = (ie_rx & rx_avail) | (ie_tx & tx_empty) | (ie_err & |STATUS[8:5]). It is registered.
- A W1C write in the same cycle as a flag-set event: the set wins.

Optional Feature:
- UART_PARITY_EN defined: PARITY states exist in both FSMs. CTRL[6:5] select none/even/odd parity, and parity_err is live.
- Undefined: no PARITY states. CTRL[6:5] read 0 and writes to them are ignored. STATUS[8] reads 0.

Decomposition:
- Shared package uart_pkg: register offsets (DATA, STATUS, CTRL, BAUD_DIV, LEVEL), STATUS/CTRL bit indices, TX/RX state encodings, and a clog2 function.
- One sub-module, uart_sync_fifo, parametrised by width and depth. It provides push, pop, din, dout, full, empty and count. It is instantiated twice.

Test Plan:
- Reset: pulse rst low mid-frame -> uart_tx=1 immediately; STATUS reads 0x004; BAUD_DIV reads 12 (25 MHz / 115200).
- TX: BAUD_DIV=0, CTRL=0x02, write 0x55 -> uart_tx shows start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 16 clk wide; tx_busy=1 for 160 clk.
- TX overflow: tx_en=0, write 17 bytes -> LEVEL tx_count=16, tx_ovf=1; writing STATUS=0x80 clears it.
- RX: rx_en=1, drive 0xA3 at 16-clk bit time -> rx_avail=1, DATA reads 0xA3 on the next cycle, then rx_avail=0. A bad stop bit sets frame_err=1 and leaves rx_count=0.
- RX overflow and wrap: receive 20 bytes without reading -> rx_count=16, rx_ovf=1. Reading 16 returns the first 16 in order, then 0.
- IRQ: ie_rx=1, receive one byte -> irq=1 within 2 cycles of the stop sample; after the DATA read, irq=0. With UART_PARITY_EN and even parity, send 0x01 with parity 0 -> parity_err=1, no push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register map, STATUS/CTRL bit
// positions, FSM encodings and a constant clog2 helper.
package uart_pkg;

  localparam logic [4:0] ADDR_DATA   = 5'h00;
  localparam logic [4:0] ADDR_STATUS = 5'h04;
  localparam logic [4:0] ADDR_CTRL   = 5'h08;
  localparam logic [4:0] ADDR_BAUD   = 5'h0C;
  localparam logic [4:0] ADDR_LEVEL  = 5'h10;

  localparam int ST_RX_AVAIL  = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_FULL   = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_RX_OVF    = 5;
  localparam int ST_FRAME_ERR = 6;
  localparam int ST_TX_OVF    = 7;
  localparam int ST_PAR_ERR   = 8;

  localparam int CT_RX_EN   = 0;
  localparam int CT_TX_EN   = 1;
  localparam int CT_IE_RX   = 2;
  localparam int CT_IE_TX   = 3;
  localparam int CT_IE_ERR  = 4;
  localparam int CT_PAR_ODD = 5;
  localparam int CT_PAR_ON  = 6;
  localparam int CT_LED     = 7;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with AW+1 bit pointers; full/empty come from the MSB
// difference so wrap-around needs no special handling.
module uart_sync_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic             w_do_push, w_do_pop;

  // A pop frees the slot first, so push into a full FIFO is accepted alongside it.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count = r_wptr - r_rptr;
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/peripheral_uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, 16x baud generator, sticky errors and
// level irq. Define UART_PARITY_EN to build the parity states and CTRL[6:5].
module peripheral_uart_fifo import uart_pkg::*; #(
  parameter int clk_freq   = 25000000,
  parameter int baud       = 115200,
  parameter int fifo_depth = 16,
  parameter int data_bits  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq,
  output logic        ledout
);

  localparam int          AW       = clog2(fifo_depth);
  localparam int          DB       = data_bits;
  localparam logic [15:0] BAUD_RST = 16'(clk_freq / (16 * baud) - 1);
`ifdef UART_PARITY_EN
  localparam logic        PAR_EN   = 1'b1;
`else
  localparam logic        PAR_EN   = 1'b0;
`endif
  localparam logic [7:0]  CTRL_MASK = PAR_EN ? 8'hFF : 8'h9F;

  logic [7:0]    r_ctrl;
  logic [15:0]   r_baud, r_bcnt;
  logic          r_rx_ovf, r_frame_err, r_tx_ovf, r_par_err;
  logic          r_irq;
  logic [31:0]   r_dout;
  logic [31:0]   w_status, w_rdata;
  logic [4:0]    w_reg;
  logic          w_rd, w_wr, w_wr_data, w_wr_stat, w_wr_ctrl, w_wr_baud;
  logic          w_tick, w_par_on, w_unused;

  logic [DB-1:0] w_tx_dout, w_rx_dout;
  logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [AW:0]   w_tx_count, w_rx_count;
  logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_set_txovf;

  tx_state_t     r_tx_st;
  logic [3:0]    r_tx_sub;
  logic [2:0]    r_tx_bit;
  logic [DB-1:0] r_tx_sh;
  logic          r_tx_par, r_tx_o;

  rx_state_t     r_rx_st;
  logic [1:0]    r_sync;
  logic          r_rx_prev;
  logic [3:0]    r_rx_sub;
  logic [2:0]    r_rx_bit;
  logic [DB-1:0] r_rx_sh;
  logic          r_rx_parbit;
  logic          w_rx, w_rx_stop, w_par_bad, w_rx_good;
  logic          w_set_rxovf, w_set_ferr, w_set_perr;

  assign w_unused  = ^{d_in[31:16], addr[1:0]};
  assign w_reg     = {addr[4:2], 2'b00};
  assign w_rd      = cs & rd;
  assign w_wr      = cs & wr;
  assign w_wr_data = w_wr && (w_reg == ADDR_DATA);
  assign w_wr_stat = w_wr && (w_reg == ADDR_STATUS);
  assign w_wr_ctrl = w_wr && (w_reg == ADDR_CTRL);
  assign w_wr_baud = w_wr && (w_reg == ADDR_BAUD);
  assign w_par_on  = PAR_EN & r_ctrl[CT_PAR_ON];

  uart_sync_fifo #(.WIDTH(DB), .DEPTH(fifo_depth)) u_tx_fifo (
    .i_clk(clk), .i_rst_n(rst), .i_push(w_tx_push), .i_pop(w_tx_pop),
    .i_din(d_in[DB-1:0]), .o_dout(w_tx_dout), .o_full(w_tx_full),
    .o_empty(w_tx_empty), .o_count(w_tx_count)
  );

  uart_sync_fifo #(.WIDTH(DB), .DEPTH(fifo_depth)) u_rx_fifo (
    .i_clk(clk), .i_rst_n(rst), .i_push(w_rx_push), .i_pop(w_rx_pop),
    .i_din(r_rx_sh), .o_dout(w_rx_dout), .o_full(w_rx_full),
    .o_empty(w_rx_empty), .o_count(w_rx_count)
  );

  assign w_tx_pop    = w_tick && (r_tx_st == TX_IDLE) && r_ctrl[CT_TX_EN] && !w_tx_empty;
  assign w_tx_push   = w_wr_data & (~w_tx_full | w_tx_pop);
  assign w_set_txovf = w_wr_data & w_tx_full & ~w_tx_pop;
  assign w_rx_pop    = w_rd && (w_reg == ADDR_DATA) && !w_rx_empty;

  // Baud generator: tick on zero, reload; a BAUD_DIV write restarts the count.
  assign w_tick = (r_bcnt == 16'd0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_bcnt <= BAUD_RST;
    else if (w_wr_baud) r_bcnt <= d_in[15:0];
    else if (w_tick)    r_bcnt <= r_baud;
    else                r_bcnt <= r_bcnt - 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_st  <= TX_IDLE;
      r_tx_sub <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_tx_par <= 1'b0;
      r_tx_o   <= 1'b1;
    end else if (w_tick) begin
      if (r_tx_st == TX_IDLE) begin
        if (w_tx_pop) begin
          r_tx_st  <= TX_START;
          r_tx_sub <= '0;
          r_tx_sh  <= w_tx_dout;
          r_tx_par <= (^w_tx_dout) ^ r_ctrl[CT_PAR_ODD];
          r_tx_o   <= 1'b0;
        end
      end else begin
        r_tx_sub <= r_tx_sub + 4'd1;
        if (r_tx_sub == 4'd15) begin
          case (r_tx_st)
            TX_START: begin
              r_tx_st  <= TX_DATA;
              r_tx_bit <= '0;
              r_tx_o   <= r_tx_sh[0];
              r_tx_sh  <= r_tx_sh >> 1;
            end
            TX_DATA: begin
              if (r_tx_bit == 3'(DB - 1)) begin
                r_tx_st <= w_par_on ? TX_PARITY : TX_STOP;
                r_tx_o  <= w_par_on ? r_tx_par : 1'b1;
              end else begin
                r_tx_bit <= r_tx_bit + 3'd1;
                r_tx_o   <= r_tx_sh[0];
                r_tx_sh  <= r_tx_sh >> 1;
              end
            end
            TX_PARITY: begin
              r_tx_st <= TX_STOP;
              r_tx_o  <= 1'b1;
            end
            default: r_tx_st <= TX_IDLE;
          endcase
        end
      end
    end
  end

  // Byte verdict is taken at the mid-stop sample.
  assign w_rx        = r_sync[1];
  assign w_rx_stop   = w_tick && (r_rx_st == RX_STOP) && (r_rx_sub == 4'd15);
  assign w_par_bad   = w_par_on & (r_rx_parbit != ((^r_rx_sh) ^ r_ctrl[CT_PAR_ODD]));
  assign w_rx_good   = w_rx_stop & w_rx & ~w_par_bad;
  assign w_rx_push   = w_rx_good & ~w_rx_full;
  assign w_set_rxovf = w_rx_good & w_rx_full;
  assign w_set_ferr  = w_rx_stop & ~w_rx;
  assign w_set_perr  = w_rx_stop & w_rx & w_par_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync      <= 2'b11;
      r_rx_prev   <= 1'b1;
      r_rx_st     <= RX_IDLE;
      r_rx_sub    <= '0;
      r_rx_bit    <= '0;
      r_rx_sh     <= '0;
      r_rx_parbit <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], uart_rx};
      if (w_tick) begin
        r_rx_prev <= w_rx;
        case (r_rx_st)
          RX_IDLE: if (r_ctrl[CT_RX_EN] && r_rx_prev && !w_rx) begin
            r_rx_st  <= RX_START;
            r_rx_sub <= '0;
          end
          RX_START: begin
            if (r_rx_sub == 4'd7) begin
              r_rx_st  <= w_rx ? RX_IDLE : RX_DATA;
              r_rx_sub <= '0;
              r_rx_bit <= '0;
            end else r_rx_sub <= r_rx_sub + 4'd1;
          end
          RX_DATA: begin
            r_rx_sub <= r_rx_sub + 4'd1;
            if (r_rx_sub == 4'd15) begin
              r_rx_sh  <= {w_rx, r_rx_sh[DB-1:1]};
              r_rx_bit <= r_rx_bit + 3'd1;
              if (r_rx_bit == 3'(DB - 1)) r_rx_st <= w_par_on ? RX_PARITY : RX_STOP;
            end
          end
          RX_PARITY: begin
            r_rx_sub <= r_rx_sub + 4'd1;
            if (r_rx_sub == 4'd15) begin
              r_rx_parbit <= w_rx;
              r_rx_st     <= RX_STOP;
            end
          end
          default: begin
            r_rx_sub <= r_rx_sub + 4'd1;
            if (r_rx_sub == 4'd15) r_rx_st <= RX_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_status               = '0;
    w_status[ST_RX_AVAIL]  = ~w_rx_empty;
    w_status[ST_RX_FULL]   = w_rx_full;
    w_status[ST_TX_EMPTY]  = w_tx_empty;
    w_status[ST_TX_FULL]   = w_tx_full;
    w_status[ST_TX_BUSY]   = (r_tx_st != TX_IDLE);
    w_status[ST_RX_OVF]    = r_rx_ovf;
    w_status[ST_FRAME_ERR] = r_frame_err;
    w_status[ST_TX_OVF]    = r_tx_ovf;
    w_status[ST_PAR_ERR]   = r_par_err;
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      ADDR_DATA:   if (!w_rx_empty) w_rdata[DB-1:0] = w_rx_dout;
      ADDR_STATUS: w_rdata = w_status;
      ADDR_CTRL:   w_rdata[7:0] = r_ctrl;
      ADDR_BAUD:   w_rdata[15:0] = r_baud;
      ADDR_LEVEL: begin
        w_rdata[8:0]   = 9'(w_rx_count);
        w_rdata[24:16] = 9'(w_tx_count);
      end
      default: ;
    endcase
  end

  // Sticky flags: a set event in the same cycle as a W1C wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl      <= '0;
      r_baud      <= BAUD_RST;
      r_rx_ovf    <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_par_err   <= 1'b0;
      r_irq       <= 1'b0;
      r_dout      <= '0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= d_in[7:0] & CTRL_MASK;
      if (w_wr_baud) r_baud <= d_in[15:0];
      r_rx_ovf    <= w_set_rxovf | (r_rx_ovf    & ~(w_wr_stat & d_in[ST_RX_OVF]));
      r_frame_err <= w_set_ferr  | (r_frame_err & ~(w_wr_stat & d_in[ST_FRAME_ERR]));
      r_tx_ovf    <= w_set_txovf | (r_tx_ovf    & ~(w_wr_stat & d_in[ST_TX_OVF]));
      r_par_err   <= w_set_perr  | (r_par_err   & ~(w_wr_stat & d_in[ST_PAR_ERR]));
      r_irq       <= (r_ctrl[CT_IE_RX]  & ~w_rx_empty) |
                     (r_ctrl[CT_IE_TX]  & w_tx_empty) |
                     (r_ctrl[CT_IE_ERR] & (|w_status[8:5]));
      r_dout      <= w_rd ? w_rdata : '0;
    end
  end

  assign d_out   = r_dout;
  assign uart_tx = r_tx_o;
  assign irq     = r_irq;
  assign ledout  = r_ctrl[CT_LED];

endmodule

// File: tb/tb_peripheral_uart_fifo.sv
// Scoreboard bench: bus reads queue their expected data, a negedge monitor
// compares d_out one cycle later; serial and irq checks are made inline.
module tb_peripheral_uart_fifo;

  localparam logic [4:0] A_DATA = 5'h00, A_STAT = 5'h04, A_CTRL = 5'h08,
                         A_BAUD = 5'h0C, A_LVL  = 5'h10, A_NONE = 5'h14;

  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] d_in = '0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] d_out;
  logic        uart_tx, irq, ledout;
  logic        uart_rx = 1'b1;

  int n_chk = 0, n_pass = 0;

  typedef struct { string name; logic [31:0] exp; } exp_t;
  exp_t sbq[$];
  logic rdq = 1'b0;
  logic smp [160];

  peripheral_uart_fifo dut (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq), .ledout(ledout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rdq <= cs & rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rdq) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected read: got 0x%08h, nothing expected", d_out);
      end else begin
        e = sbq.pop_front();
        chk(e.name, d_out, e.exp);
      end
    end
  end

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    cs = 1'b1; rd = 1'b1; addr = a;
    sbq.push_back('{name, exp});
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("uart_tx high in reset", uart_tx, 1);
    chk("d_out zero in reset", d_out, 0);
    chk("irq low in reset", irq, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic rx_bit(input logic v);
    uart_rx = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input logic par_en, input logic par);
    @(posedge clk); #1;
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    if (par_en) rx_bit(par);
    rx_bit(stop);
    uart_rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_low(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) seen = 1'b1;
    end
    chk("tx start bit seen", 32'(seen), 1);
  endtask

  // Records 160 negedge samples from the start bit and checks each bit cell is 16 clk wide.
  task automatic tx_frame(input logic [7:0] b);
    bit   seen;
    logic exp_bit;
    int   cnt;
    wait_tx_low(seen);
    if (seen) begin
      smp[0] = uart_tx;
      fork
        begin
          for (int i = 1; i < 160; i++) begin
            @(negedge clk);
            smp[i] = uart_tx;
          end
        end
        rd_reg(A_STAT, 32'h014, "status during tx");
      join
      for (int k = 0; k < 10; k++) begin
        exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        cnt = 0;
        for (int j = 0; j < 16; j++) if (smp[16*k + j] === exp_bit) cnt++;
        chk($sformatf("tx 0x%02h cell %0d samples", b, k), 32'(cnt), 16);
      end
      repeat (20) @(negedge clk);
      rd_reg(A_STAT, 32'h004, "status after tx");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // reset state and register map
    chk("irq after reset", irq, 0);
    chk("uart_tx after reset", uart_tx, 1);
    rd_reg(A_STAT, 32'h004, "status reset");
    rd_reg(A_BAUD, 32'd12,  "baud reset");
    rd_reg(A_CTRL, 32'h000, "ctrl reset");
    rd_reg(A_LVL,  32'h000, "level reset");
    rd_reg(A_DATA, 32'h000, "data empty read");
    rd_reg(A_NONE, 32'h000, "unmapped read");
    wr_reg(A_CTRL, 32'h80);
    chk("ledout on", ledout, 1);
    rd_reg(A_CTRL, 32'h80, "ctrl led");
    wr_reg(A_CTRL, 32'hFF);
`ifdef UART_PARITY_EN
    rd_reg(A_CTRL, 32'hFF, "ctrl all ones");
`else
    rd_reg(A_CTRL, 32'h9F, "ctrl parity bits masked");
`endif
    repeat (2) @(negedge clk);
    chk("irq ie_tx with tx empty", irq, 1);
    wr_reg(A_CTRL, 32'h00);
    repeat (2) @(negedge clk);
    chk("irq cleared", irq, 0);

    // transmit
    wr_reg(A_BAUD, 32'h0);
    rd_reg(A_BAUD, 32'h0, "baud written");
    wr_reg(A_CTRL, 32'h02);
    wr_reg(A_DATA, 32'h55);
    tx_frame(8'h55);
    wr_reg(A_DATA, 32'hC4);
    tx_frame(8'hC4);

    // reset during a frame
    wr_reg(A_DATA, 32'h00);
    wait_tx_low(seen);
    repeat (10) @(negedge clk);
    do_reset();
    rd_reg(A_BAUD, 32'd12,  "baud after reset");
    rd_reg(A_STAT, 32'h004, "status after reset");
    rd_reg(A_LVL,  32'h000, "level after reset");

    // TX overflow with tx disabled
    for (int i = 0; i < 17; i++) wr_reg(A_DATA, 32'(i));
    rd_reg(A_LVL,  32'h0010_0000, "tx level full");
    rd_reg(A_STAT, 32'h088, "status tx full+ovf");
    wr_reg(A_STAT, 32'h80);
    rd_reg(A_STAT, 32'h008, "tx_ovf cleared");
    do_reset();

    // receive
    wr_reg(A_BAUD, 32'h0);
    wr_reg(A_CTRL, 32'h01);
    send_rx(8'hA3, 1'b1, 1'b0, 1'b0);
    rd_reg(A_STAT, 32'h005, "rx_avail set");
    rd_reg(A_DATA, 32'hA3,  "rx data A3");
    rd_reg(A_STAT, 32'h004, "rx_avail clear");
    send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
    rd_reg(A_STAT, 32'h044, "frame_err set");
    rd_reg(A_LVL,  32'h000, "bad frame not pushed");
    wr_reg(A_STAT, 32'h40);
    rd_reg(A_STAT, 32'h004, "frame_err cleared");

    // RX overflow and pointer wrap
    for (int i = 0; i < 20; i++) send_rx(8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
    rd_reg(A_LVL,  32'h010, "rx level full");
    rd_reg(A_STAT, 32'h027, "status rx full+ovf");
    for (int i = 0; i < 16; i++) rd_reg(A_DATA, 32'(8'h10 + i), $sformatf("rx order %0d", i));
    rd_reg(A_DATA, 32'h0, "rx drained read");
    rd_reg(A_LVL,  32'h0, "rx level empty");

    // interrupts
    wr_reg(A_CTRL, 32'h05);
    repeat (2) @(negedge clk);
    chk("irq idle ie_rx", irq, 0);
    send_rx(8'h3C, 1'b1, 1'b0, 1'b0);
    chk("irq on rx byte", irq, 1);
    rd_reg(A_DATA, 32'h3C, "rx data 3C");
    repeat (2) @(negedge clk);
    chk("irq after data read", irq, 0);
    wr_reg(A_CTRL, 32'h11);
    repeat (2) @(negedge clk);
    chk("irq ie_err with rx_ovf", irq, 1);
    wr_reg(A_STAT, 32'h20);
    repeat (2) @(negedge clk);
    chk("irq after w1c", irq, 0);
    rd_reg(A_STAT, 32'h004, "status clean");

`ifdef UART_PARITY_EN
    wr_reg(A_CTRL, 32'h41);
    send_rx(8'h01, 1'b1, 1'b1, 1'b0);
    rd_reg(A_STAT, 32'h104, "parity_err set");
    rd_reg(A_LVL,  32'h000, "parity bad not pushed");
    send_rx(8'h01, 1'b1, 1'b1, 1'b1);
    rd_reg(A_DATA, 32'h01, "even parity ok");
    wr_reg(A_CTRL, 32'h61);
    send_rx(8'h01, 1'b1, 1'b1, 1'b0);
    rd_reg(A_DATA, 32'h01, "odd parity ok");
    wr_reg(A_STAT, 32'h100);
    rd_reg(A_STAT, 32'h004, "parity_err cleared");
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
